relu_wb_sched: RTL and testbench

- Output-stage scheduler between the PE-array partial-sum outputs and the activation buffer.
- Round-robin arbitrates N_REQ 32-bit psum streams and applies ReLU, right-shift and saturation (the same rule as the existing ReLU datapath).
- Packs PACK activations per word and issues sequential buffer writes for a programmed job length.
- Raises done when the job completes.

---
 rtl/relu_wb_sched.sv | 205 ++++++++++++++++++++
 tb/tb_relu_wb_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/relu_wb_sched.sv
// Output-stage scheduler: round-robin psum arbitration, ReLU/shift/saturate, pack and buffer write.
// Optional RELU_WB_STATS_EN adds zero_cnt/sat_cnt activation statistics outputs.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | arbitrating psums and issuing buffer writes
// DONE  | one-cycle job-complete pulse
module relu_wb_sched #(
  parameter int N_REQ         = 4,
  parameter int DATA_BITWIDTH = 8,
  parameter int SHIFT         = 6,
  parameter int PACK          = 4,
  parameter int ADDR_W        = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               num_words,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic [N_REQ-1:0]                psum_valid,
  input  logic [N_REQ*32-1:0]             psum_data,
  output logic [N_REQ-1:0]                psum_ready,
  output logic                            wr_en,
  output logic [ADDR_W-1:0]               wr_addr,
  output logic [PACK*DATA_BITWIDTH-1:0]   wr_data,
  output logic                            busy,
  output logic                            done
`ifdef RELU_WB_STATS_EN
  ,
  output logic [15:0]                     zero_cnt,
  output logic [15:0]                     sat_cnt
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BC_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PW    = PACK * DATA_BITWIDTH;
  localparam logic [31:0] ACT_MAX = (32'd1 << DATA_BITWIDTH) - 32'd1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] num_words_q, num_words_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [PW-1:0]     pack_q, pack_d;
  logic              last_acc_q, last_acc_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PW-1:0]     wr_data_q, wr_data_d;
  logic [15:0]       zero_cnt_q, zero_cnt_d;
  logic [15:0]       sat_cnt_q, sat_cnt_d;

  logic                     gnt_vld;
  logic [PTR_W-1:0]         gnt_idx;
  logic                     xfer;
  logic [31:0]              d_sel;
  logic [31:0]              d_shr;
  logic [DATA_BITWIDTH-1:0] act;
  logic                     act_neg;
  logic                     act_sat;
  logic [PW-1:0]            pack_next;
  int                       idx;

  // Round-robin search starting at the pointer; arbitration stops once the final byte is in.
  always_comb begin
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    idx        = 0;
    psum_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_vld && psum_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
    xfer = (state_q == S_RUN) && !last_acc_q && gnt_vld;
    if (xfer) psum_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    d_sel   = psum_data[int'(gnt_idx)*32 +: 32];
    d_shr   = d_sel >> SHIFT;
    act     = '0;
    act_neg = 1'b0;
    act_sat = 1'b0;
    if (d_sel[31]) begin
      act_neg = 1'b1;
    end else if (d_shr > ACT_MAX) begin
      act     = '1;
      act_sat = 1'b1;
    end else begin
      act = d_shr[DATA_BITWIDTH-1:0];
    end
    pack_next = pack_q;
    pack_next[int'(byte_cnt_q)*DATA_BITWIDTH +: DATA_BITWIDTH] = act;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    num_words_d = num_words_q;
    base_d      = base_q;
    pack_d      = pack_q;
    last_acc_d  = last_acc_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    zero_cnt_d  = zero_cnt_q;
    sat_cnt_d   = sat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_words_d = num_words;
          base_d      = base_addr;
          ptr_d       = '0;
          byte_cnt_d  = '0;
          word_cnt_d  = '0;
          pack_d      = '0;
          last_acc_d  = 1'b0;
          zero_cnt_d  = '0;
          sat_cnt_d   = '0;
          state_d     = (num_words != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (xfer) begin
          pack_d = pack_next;
          ptr_d  = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
          if (act_neg && zero_cnt_q != 16'hFFFF) zero_cnt_d = zero_cnt_q + 16'd1;
          if (act_sat && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
          if (byte_cnt_q == BC_W'(PACK - 1)) begin
            byte_cnt_d = '0;
            wr_en_d    = 1'b1;
            wr_addr_d  = base_q + word_cnt_q;
            wr_data_d  = pack_next;
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == num_words_q - 1'b1) last_acc_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
        if (wr_en_q && last_acc_q) state_d = S_DONE;
      end
      S_DONE: begin
        last_acc_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      num_words_q <= '0;
      base_q      <= '0;
      pack_q      <= '0;
      last_acc_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      zero_cnt_q  <= '0;
      sat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      num_words_q <= num_words_d;
      base_q      <= base_d;
      pack_q      <= pack_d;
      last_acc_q  <= last_acc_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      zero_cnt_q  <= zero_cnt_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);

`ifdef RELU_WB_STATS_EN
  assign zero_cnt = zero_cnt_q;
  assign sat_cnt  = sat_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{zero_cnt_q, sat_cnt_q};
`endif

endmodule

// File: tb/tb_relu_wb_sched.sv
// Directed self-checking bench for relu_wb_sched; stats checks are compiled in with RELU_WB_STATS_EN.
module tb_relu_wb_sched;
  localparam int N_REQ = 4;
  localparam int DW    = 8;
  localparam int PACK  = 4;
  localparam int AW    = 10;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [AW-1:0]        num_words;
  logic [AW-1:0]        base_addr;
  logic [N_REQ-1:0]     psum_valid;
  logic [N_REQ*32-1:0]  psum_data;
  logic [N_REQ-1:0]     psum_ready;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [PACK*DW-1:0]   wr_data;
  logic                 busy;
  logic                 done;
`ifdef RELU_WB_STATS_EN
  logic [15:0]          zero_cnt;
  logic [15:0]          sat_cnt;
`endif

  int n_chk;
  int n_fail;

  relu_wb_sched #(.N_REQ(N_REQ), .DATA_BITWIDTH(DW), .SHIFT(6), .PACK(PACK), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .base_addr(base_addr),
    .psum_valid(psum_valid), .psum_data(psum_data), .psum_ready(psum_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
`ifdef RELU_WB_STATS_EN
    , .zero_cnt(zero_cnt), .sat_cnt(sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle; returns at the first falling edge with the job in RUN.
  task automatic start_job(input logic [AW-1:0] nw, input logic [AW-1:0] ba);
    @(negedge clk);
    start = 1'b1; num_words = nw; base_addr = ba;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    n_chk++; if (wr_addr !== 10'h000) begin n_fail++; $display("FAIL reset_wr_addr: got %h expected 000", wr_addr); end
    n_chk++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
    n_chk++; if (psum_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", psum_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [31:0] vals [4];
    vals[0] = 32'h40; vals[1] = 32'h80; vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h7FFF_FFFF;
    psum_valid = 4'b0001;
    psum_data[31:0] = vals[0];
    start_job(10'd1, 10'h010);
    for (int k = 0; k < 4; k++) begin
      psum_data[31:0] = vals[k];
      #1;
      n_chk++; if (psum_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready[%0d]: got %b expected 0001", k, psum_ready); end
      n_chk++; if (busy !== 1'b1 || wr_en !== 1'b0) begin n_fail++; $display("FAIL single_busy[%0d]: got busy=%b wr_en=%b expected 1 0", k, busy, wr_en); end
      @(negedge clk);
    end
    #1;
    n_chk++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL single_wr_en: got %b expected 1", wr_en); end
    n_chk++; if (wr_addr !== 10'h010) begin n_fail++; $display("FAIL single_wr_addr: got %h expected 010", wr_addr); end
    n_chk++; if (wr_data !== 32'hFF00_0201) begin n_fail++; $display("FAIL single_wr_data: got %h expected ff000201", wr_data); end
    n_chk++; if (psum_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_after_last: got %b expected 0000", psum_ready); end
    @(negedge clk); #1;
    n_chk++; if ({done, busy, wr_en} !== 3'b100) begin n_fail++; $display("FAIL single_done: got done/busy/wr_en=%b expected 100", {done, busy, wr_en}); end
    @(negedge clk); #1;
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b expected 0", done); end
    n_chk++; if (wr_data !== 32'hFF00_0201) begin n_fail++; $display("FAIL single_data_hold: got %h expected ff000201", wr_data); end
    psum_valid = 4'b0000;
  endtask

  // All requesters valid, start pulsed mid-job, address wraps from 0x3FF to 0x000.
  task automatic test_all_valid();
    for (int i = 0; i < N_REQ; i++) psum_data[i*32 +: 32] = 32'((i + 1) * 64);
    psum_valid = 4'b1111;
    start_job(10'd2, 10'h3FF);
    for (int k = 0; k < 8; k++) begin
      #1;
      n_chk++; if (psum_ready !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rr_order[%0d]: got %b expected %b", k, psum_ready, 4'(1 << (k % 4))); end
      if (k == 2) begin start = 1'b1; num_words = 10'd0; end
      if (k == 3) start = 1'b0;
      if (k == 4) begin
        n_chk++; if ({wr_en, wr_addr} !== {1'b1, 10'h3FF}) begin n_fail++; $display("FAIL rr_word0: got wr_en=%b addr=%h expected 1 3ff", wr_en, wr_addr); end
        n_chk++; if (wr_data !== 32'h0403_0201) begin n_fail++; $display("FAIL rr_word0_data: got %h expected 04030201", wr_data); end
      end
      if (k == 5) begin
        n_chk++; if ({wr_en, wr_addr} !== {1'b0, 10'h3FF}) begin n_fail++; $display("FAIL rr_wr_pulse: got wr_en=%b addr=%h expected 0 3ff", wr_en, wr_addr); end
      end
      @(negedge clk);
    end
    #1;
    n_chk++; if ({wr_en, wr_addr} !== {1'b1, 10'h000}) begin n_fail++; $display("FAIL rr_word1: got wr_en=%b addr=%h expected 1 000", wr_en, wr_addr); end
    n_chk++; if (wr_data !== 32'h0403_0201) begin n_fail++; $display("FAIL rr_word1_data: got %h expected 04030201", wr_data); end
    n_chk++; if (psum_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_no_grant_after_last: got %b expected 0000", psum_ready); end
    @(negedge clk); #1;
    n_chk++; if ({done, psum_ready} !== 5'b1_0000) begin n_fail++; $display("FAIL rr_done: got done=%b ready=%b expected 1 0000", done, psum_ready); end
    psum_valid = 4'b0000;
    @(negedge clk);
  endtask

  // Requesters 1 and 3 only; an idle cycle holds the pointer at 2.
  task automatic test_sparse();
    logic [3:0] vld [9];
    logic [3:0] exp_rdy [9];
    vld[0] = 4'b0010; exp_rdy[0] = 4'b0010;
    vld[1] = 4'b0000; exp_rdy[1] = 4'b0000;
    for (int k = 2; k < 9; k++) begin
      vld[k] = 4'b1010;
      exp_rdy[k] = (k % 2 == 0) ? 4'b1000 : 4'b0010;
    end
    psum_data[0*32 +: 32] = 32'h40;
    psum_data[1*32 +: 32] = 32'h100;
    psum_data[2*32 +: 32] = 32'h40;
    psum_data[3*32 +: 32] = 32'h3FFF;
    psum_valid = 4'b0000;
    start_job(10'd2, 10'h020);
    for (int k = 0; k < 9; k++) begin
      psum_valid = vld[k];
      #1;
      n_chk++; if (psum_ready !== exp_rdy[k]) begin n_fail++; $display("FAIL sparse_grant[%0d]: got %b expected %b", k, psum_ready, exp_rdy[k]); end
      if (k == 5) begin
        n_chk++; if ({wr_en, wr_addr} !== {1'b1, 10'h020}) begin n_fail++; $display("FAIL sparse_word0: got wr_en=%b addr=%h expected 1 020", wr_en, wr_addr); end
        n_chk++; if (wr_data !== 32'hFF04_FF04) begin n_fail++; $display("FAIL sparse_word0_data: got %h expected ff04ff04", wr_data); end
      end
      @(negedge clk);
    end
    #1;
    n_chk++; if ({wr_en, wr_addr} !== {1'b1, 10'h021}) begin n_fail++; $display("FAIL sparse_word1: got wr_en=%b addr=%h expected 1 021", wr_en, wr_addr); end
    n_chk++; if (wr_data !== 32'hFF04_FF04) begin n_fail++; $display("FAIL sparse_word1_data: got %h expected ff04ff04", wr_data); end
    psum_valid = 4'b0000;
    @(negedge clk); #1;
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL sparse_done: got %b expected 1", done); end
    @(negedge clk);
  endtask

  task automatic test_zero_words();
    start_job(10'd0, 10'h155);
    #1;
    n_chk++; if ({done, busy, wr_en} !== 3'b100) begin n_fail++; $display("FAIL zero_words_done: got done/busy/wr_en=%b expected 100", {done, busy, wr_en}); end
    @(negedge clk); #1;
    n_chk++; if ({done, busy, wr_en} !== 3'b000) begin n_fail++; $display("FAIL zero_words_after: got done/busy/wr_en=%b expected 000", {done, busy, wr_en}); end
  endtask

  task automatic test_stats();
    logic [31:0] vals [4];
    vals[0] = 32'hFFFF_FFFB; vals[1] = 32'h4000; vals[2] = 32'h3FC0; vals[3] = 32'h0;
    psum_valid = 4'b0001;
    psum_data[31:0] = vals[0];
    start_job(10'd1, 10'h100);
    for (int k = 0; k < 4; k++) begin
      psum_data[31:0] = vals[k];
      @(negedge clk);
    end
    #1;
    n_chk++; if ({wr_en, wr_addr} !== {1'b1, 10'h100}) begin n_fail++; $display("FAIL stats_wr: got wr_en=%b addr=%h expected 1 100", wr_en, wr_addr); end
    n_chk++; if (wr_data !== 32'h00FF_FF00) begin n_fail++; $display("FAIL stats_wr_data: got %h expected 00ffff00", wr_data); end
`ifdef RELU_WB_STATS_EN
    n_chk++; if (zero_cnt !== 16'd1) begin n_fail++; $display("FAIL stats_zero_cnt: got %0d expected 1", zero_cnt); end
    n_chk++; if (sat_cnt !== 16'd1) begin n_fail++; $display("FAIL stats_sat_cnt: got %0d expected 1", sat_cnt); end
`endif
    psum_valid = 4'b0000;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n_wr;
    n_wr = 0;
    psum_valid = 4'b0001;
    psum_data[31:0] = 32'h40;
    start_job(10'd1, 10'h050);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({wr_en, busy, done} !== 3'b000) begin n_fail++; $display("FAIL abort_ctrl: got wr_en/busy/done=%b expected 000", {wr_en, busy, done}); end
    n_chk++; if (wr_addr !== 10'h000 || wr_data !== 32'h0) begin n_fail++; $display("FAIL abort_wr: got addr=%h data=%h expected 000 0", wr_addr, wr_data); end
    n_chk++; if (psum_ready !== 4'b0000) begin n_fail++; $display("FAIL abort_ready: got %b expected 0000", psum_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    psum_data[31:0] = 32'h80;
    start_job(10'd1, 10'h060);
    for (int k = 0; k < 4; k++) begin
      #1;
      if (wr_en === 1'b1) n_wr++;
      @(negedge clk);
    end
    #1;
    n_chk++; if (n_wr !== 0) begin n_fail++; $display("FAIL abort_early_write: got %0d writes expected 0", n_wr); end
    n_chk++; if ({wr_en, wr_addr} !== {1'b1, 10'h060}) begin n_fail++; $display("FAIL abort_new_job: got wr_en=%b addr=%h expected 1 060", wr_en, wr_addr); end
    n_chk++; if (wr_data !== 32'h0202_0202) begin n_fail++; $display("FAIL abort_new_data: got %h expected 02020202", wr_data); end
    psum_valid = 4'b0000;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; num_words = '0; base_addr = '0;
    psum_valid = '0; psum_data = '0;
    test_reset();
    test_single();
    test_all_valid();
    test_sparse();
    test_zero_words();
    test_stats();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
